uart_tx_arbiter: RTL and testbench

- Shares one 9600-baud serial transmitter between two byte sources: requester 0 is the AVR bridge path, requester 1 is local FPGA status/debug logic.
- Each requester gets its own byte FIFO. This absorbs fast bursts that the slow UART cannot accept.
- A round-robin scheduler drains the FIFOs one byte at a time into the transmitter's data/new_data handshake.
- Per-requester block outputs give backpressure before data loss.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/byte_fifo.sv | 80 ++++++++
 rtl/uart_tx_arbiter.sv | 155 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package     : uart_pkg
// Description : Shared constants for the UART transmit arbiter: scheduler
//               state encodings, requester count and transmitter timing.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Scheduler state encodings
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOAD      = 3'd1;
    localparam logic [2:0] START     = 3'd2;
    localparam logic [2:0] WAIT_BUSY = 3'd3;
    localparam logic [2:0] WAIT_DONE = 3'd4;

    // Number of byte sources sharing the transmitter
    localparam int REQ_COUNT = 2;

    // Cycles to wait for the transmitter to acknowledge a start strobe
    localparam int BUSY_TIMEOUT = 4;

    // 50 MHz / 9600 baud, for transmitters built alongside this block
    localparam int CLK_PER_BIT_9600 = 5208;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : Single-clock byte FIFO with show-ahead read port, occupancy
//               count and a registered almost-full flag. A push into a full
//               FIFO is accepted only when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [7:0]        din,
    input  logic              pop,
    output logic [7:0]        dout,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] c_depth    = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] c_af_level = (ADDR_W + 1)'(DEPTH - AF_MARGIN);
    localparam logic [ADDR_W:0] c_one      = (ADDR_W + 1)'(1);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   w_count_next;
    logic              r_almost_full;
    logic              w_do_push;
    logic              w_do_pop;

    assign empty       = (r_count == '0);
    assign full        = (r_count == c_depth);
    assign almost_full = r_almost_full;
    assign count       = r_count;
    assign dout        = r_mem[r_rd_ptr];

    // A pop frees a slot in the same cycle, so a full FIFO can still take a push
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Next occupancy from the accepted push/pop pair
    always_comb begin
        w_count_next = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_next = r_count + c_one;
            2'b01:   w_count_next = r_count - c_one;
            default: w_count_next = r_count;
        endcase
    end

    // Pointers, count and almost-full flag; flag tracks the count it is stored with
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_almost_full <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count       <= w_count_next;
            r_almost_full <= (w_count_next >= c_af_level);
        end
    end

    // Storage array; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule : byte_fifo
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one serial transmitter between two byte sources. Each
//               source has its own FIFO; a round-robin scheduler moves one
//               byte at a time into the transmitter data/new_data handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 4,
    parameter int AF_MARGIN  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    output logic       req0_block,
    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    output logic       req1_block,
    output logic [7:0] tx_data,
    output logic       tx_new_data,
    input  logic       tx_busy,
    output logic       grant_id,
    output logic [1:0] overflow
);

    import uart_pkg::*;

    localparam logic [2:0] c_busy_last = 3'(BUSY_TIMEOUT - 1);

    logic [REQ_COUNT-1:0] w_valid;
    logic [REQ_COUNT-1:0] w_pop;
    logic [REQ_COUNT-1:0] w_empty;
    logic [REQ_COUNT-1:0] w_full;
    logic [REQ_COUNT-1:0] w_almost_full;
    logic [REQ_COUNT-1:0] w_has_data;
    logic [REQ_COUNT-1:0] w_drop;
    logic [7:0]           w_din   [REQ_COUNT];
    logic [7:0]           w_dout  [REQ_COUNT];
    logic [ADDR_W:0]      w_count [REQ_COUNT];

    logic [2:0] r_state;
    logic [2:0] w_state_next;
    logic [2:0] r_wait_cnt;
    logic [7:0] r_tx_data;
    logic       r_grant_id;
    logic       r_last_grant;
    logic [1:0] r_overflow;
    logic       w_any;
    logic       w_other;
    logic       w_winner;
    logic       w_take;
    logic       w_load;
    logic       w_start;

    assign w_valid  = {req1_valid, req0_valid};
    assign w_din[0] = req0_data;
    assign w_din[1] = req1_data;

    generate
        for (genvar i = 0; i < REQ_COUNT; i++) begin : g_fifo
            assign w_has_data[i] = (w_count[i] != '0);
            assign w_pop[i]      = w_load && (r_grant_id == 1'(i)) && !w_empty[i];
            // Dropped only when full and not simultaneously draining
            assign w_drop[i]     = w_valid[i] && w_full[i] && !w_pop[i];

            byte_fifo #(
                .DEPTH     (FIFO_DEPTH),
                .ADDR_W    (ADDR_W),
                .AF_MARGIN (AF_MARGIN)
            ) u_fifo (
                .clk         (clk),
                .rst         (rst),
                .push        (w_valid[i]),
                .din         (w_din[i]),
                .pop         (w_pop[i]),
                .dout        (w_dout[i]),
                .empty       (w_empty[i]),
                .full        (w_full[i]),
                .almost_full (w_almost_full[i]),
                .count       (w_count[i])
            );
        end
    endgenerate

    // Round robin: prefer the requester that did not win last time
    assign w_any    = |w_has_data;
    assign w_other  = ~r_last_grant;
    assign w_winner = w_has_data[w_other] ? w_other : r_last_grant;
    assign w_take   = (r_state == IDLE) && !tx_busy && w_any;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (w_take) w_state_next = LOAD;
            LOAD:      w_state_next = START;
            START:     w_state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy)                         w_state_next = WAIT_DONE;
                else if (r_wait_cnt == c_busy_last)  w_state_next = IDLE;
            end
            WAIT_DONE: if (!tx_busy) w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    // State-decoded controls: FIFO pop in LOAD, start strobe in START
    always_comb begin
        w_load  = 1'b0;
        w_start = 1'b0;
        case (r_state)
            LOAD:    w_load  = 1'b1;
            START:   w_start = 1'b1;
            default: ;
        endcase
    end

    // Grant bookkeeping, output byte register, busy guard counter, sticky drops
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_data    <= 8'h00;
            r_grant_id   <= 1'b0;
            r_last_grant <= 1'b1;
            r_wait_cnt   <= 3'd0;
            r_overflow   <= 2'b00;
        end else begin
            if (w_take) begin
                r_grant_id   <= w_winner;
                r_last_grant <= w_winner;
            end
            if (w_load) r_tx_data <= w_dout[r_grant_id];
            if (w_start)                     r_wait_cnt <= 3'd0;
            else if (r_state == WAIT_BUSY)   r_wait_cnt <= r_wait_cnt + 3'd1;
            r_overflow <= r_overflow | w_drop;
        end
    end

    assign tx_data     = r_tx_data;
    assign tx_new_data = w_start;
    assign grant_id    = r_grant_id;
    assign overflow    = r_overflow;
    assign req0_block  = w_almost_full[0];
    assign req1_block  = w_almost_full[1];

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Scoreboard bench for uart_tx_arbiter with a simple
//               transmitter model (normal frame, stuck busy, never busy).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int FRAME  = 12;
    localparam int NORMAL = 0;
    localparam int HOLD   = 1;
    localparam int NEVER  = 2;

    typedef struct packed {
        logic [7:0] data;
        logic       id;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req0_data, req1_data;
    logic       req0_valid, req1_valid;
    logic       req0_block, req1_block;
    logic [7:0] tx_data;
    logic       tx_new_data;
    logic       tx_busy;
    logic       grant_id;
    logic [1:0] overflow;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   n_tx = 0;
    int   last_tx_cyc = 0;
    int   tx_mode = NORMAL;
    int   frame_left = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    uart_tx_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req0_data   (req0_data),
        .req0_valid  (req0_valid),
        .req0_block  (req0_block),
        .req1_data   (req1_data),
        .req1_valid  (req1_valid),
        .req1_block  (req1_block),
        .tx_data     (tx_data),
        .tx_new_data (tx_new_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: busy for FRAME cycles after each start strobe
    always @(posedge clk) begin
        if (rst) begin
            tx_busy    <= 1'b0;
            frame_left <= 0;
        end else if (tx_mode == HOLD) begin
            tx_busy <= 1'b1;
        end else if (tx_mode == NEVER) begin
            tx_busy <= 1'b0;
        end else if (tx_new_data) begin
            tx_busy    <= 1'b1;
            frame_left <= FRAME;
        end else if (frame_left > 1) begin
            frame_left <= frame_left - 1;
        end else begin
            tx_busy    <= 1'b0;
            frame_left <= 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic id);
        exp_t e;
        e.data = d;
        e.id   = id;
        return e;
    endfunction

    // Monitor: every start strobe is matched against the scoreboard head
    always @(negedge clk) begin
        if (!rst && tx_new_data === 1'b1) begin
            n_tx++;
            last_tx_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tx: got byte %0h with none expected", tx_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("tx_data", {24'h0, tx_data}, {24'h0, mon_e.data});
                check("grant_id", {31'h0, grant_id}, {31'h0, mon_e.id});
            end
        end
    end

    task automatic push(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
        @(posedge clk); #1;
        req0_valid = v0; req0_data = d0;
        req1_valid = v1; req1_data = d1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic latency(input string name, input int want);
        int k;
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (tx_new_data === 1'b1) begin
                k = i;
                break;
            end
        end
        check(name, k, want);
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_busy === lvl) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check(name, 0, 1);
    endtask

    task automatic wait_drain(input int max, input string name);
        for (int i = 0; i < max; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int first_cyc;
        int gap;
        int tx_before;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = 8'h00; req1_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_tx_data", {24'h0, tx_data}, 0);
        check("rst_tx_new_data", {31'h0, tx_new_data}, 0);
        check("rst_grant_id", {31'h0, grant_id}, 0);
        check("rst_overflow", {30'h0, overflow}, 0);
        check("rst_req0_block", {31'h0, req0_block}, 0);
        check("rst_req1_block", {31'h0, req1_block}, 0);

        // Single byte, then a second byte once the FSM is back in IDLE
        exp_q.push_back(mk(8'h41, 1'b0));
        push(1'b1, 8'h41, 1'b0, 8'h00);
        latency("lat_single", 3);
        wait_busy(1'b1, "busy_rise_timeout");
        wait_busy(1'b0, "busy_fall_timeout");
        exp_q.push_back(mk(8'h42, 1'b0));
        push(1'b1, 8'h42, 1'b0, 8'h00);
        latency("lat_after_done", 3);
        wait_drain(100, "drain_single");

        // Contention: strict alternation starting with requester 0
        do_reset();
        tx_mode = HOLD;
        exp_q.push_back(mk(8'h10, 1'b0));
        exp_q.push_back(mk(8'h20, 1'b1));
        exp_q.push_back(mk(8'h11, 1'b0));
        exp_q.push_back(mk(8'h21, 1'b1));
        push(1'b1, 8'h10, 1'b1, 8'h20);
        push(1'b1, 8'h11, 1'b1, 8'h21);
        tx_mode = NORMAL;
        wait_drain(200, "drain_contention");

        // Backpressure and overflow on FIFO 0 with the transmitter held busy
        do_reset();
        tx_mode = HOLD;
        for (int i = 0; i < 14; i++) begin
            exp_q.push_back(mk(8'h30 + 8'(i), 1'b0));
            push(1'b1, 8'h30 + 8'(i), 1'b0, 8'h00);
            if (i == 12) check("block_at_13", {31'h0, req0_block}, 0);
            if (i == 13) check("block_at_14", {31'h0, req0_block}, 1);
        end
        for (int i = 14; i < 16; i++) begin
            exp_q.push_back(mk(8'h30 + 8'(i), 1'b0));
            push(1'b1, 8'h30 + 8'(i), 1'b0, 8'h00);
        end
        check("ovf_after_16", {30'h0, overflow}, 0);
        check("block_full", {31'h0, req0_block}, 1);
        check("req1_block_idle", {31'h0, req1_block}, 0);
        push(1'b1, 8'hEE, 1'b0, 8'h00);
        check("ovf_set", {30'h0, overflow}, 32'h1);
        tx_mode = NORMAL;
        wait_drain(1000, "drain_backpressure");
        check("ovf_sticky", {30'h0, overflow}, 32'h1);
        check("block_cleared", {31'h0, req0_block}, 0);

        // Reset during WAIT_DONE with bytes queued in both FIFOs
        do_reset();
        tx_mode = NORMAL;
        exp_q.push_back(mk(8'h50, 1'b0));
        push(1'b1, 8'h50, 1'b1, 8'h60);
        push(1'b1, 8'h51, 1'b1, 8'h61);
        push(1'b1, 8'h52, 1'b1, 8'h62);
        push(1'b1, 8'h53, 1'b0, 8'h00);
        wait_busy(1'b1, "mid_busy_timeout");
        check("mid_first_sent", exp_q.size(), 0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        check("mid_tx_data", {24'h0, tx_data}, 0);
        check("mid_tx_new_data", {31'h0, tx_new_data}, 0);
        check("mid_grant_id", {31'h0, grant_id}, 0);
        check("mid_overflow", {30'h0, overflow}, 0);
        check("mid_blocks", {30'h0, req1_block, req0_block}, 0);
        rst = 1'b0;
        tx_before = n_tx;
        repeat (40) @(posedge clk);
        check("mid_no_tx_after_rst", n_tx - tx_before, 0);
        exp_q.push_back(mk(8'h77, 1'b1));
        push(1'b0, 8'h00, 1'b1, 8'h77);
        latency("lat_after_rst", 3);
        wait_drain(100, "drain_after_rst");

        // Busy guard: transmitter never acknowledges
        do_reset();
        tx_mode = NEVER;
        exp_q.push_back(mk(8'h5A, 1'b0));
        exp_q.push_back(mk(8'h5B, 1'b0));
        tx_before = n_tx;
        push(1'b1, 8'h5A, 1'b0, 8'h00);
        push(1'b1, 8'h5B, 1'b0, 8'h00);
        first_cyc = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (first_cyc < 0 && n_tx - tx_before == 1) first_cyc = last_tx_cyc;
            if (n_tx - tx_before >= 2) break;
        end
        check("guard_both_sent", n_tx - tx_before, 2);
        gap = last_tx_cyc - first_cyc;
        check("guard_gap_ok", {31'h0, (gap >= 5 && gap <= 8)}, 1);
        check("guard_queue_empty", exp_q.size(), 0);

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_tx_arbiter
`default_nettype wire
